// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, state type and stall priority helper for pipe_ctrl
package pipe_ctrl_pkg;

  // Stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
  localparam int STALL_W = 6;

  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

  localparam logic        RST_ACTIVE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic {
    PIPE_RUN   = 1'b0,
    PIPE_FLUSH = 1'b1
  } pipe_state_t;

  // Request vector ordering is {mem, ex, id, if}; the deepest stage wins
  // because freezing it also has to freeze everything upstream of it.
  function automatic logic [STALL_W-1:0] stall_select(input logic [3:0] req);
    if (req[3])      return STALL_MEM;
    else if (req[2]) return STALL_EX;
    else if (req[1]) return STALL_ID;
    else if (req[0]) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_mem_watchdog.sv
// rtl/pipe_ctrl_mem_watchdog.sv - memory-stall watchdog: counter, compare and one-cycle timeout pulse
module pipe_ctrl_mem_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  output logic timeout
);

  localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT);

  logic [15:0] count_q;

  // Count consecutive enabled cycles; on reaching the limit pulse and start over
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      count_q <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (!count_en) begin
        count_q <= '0;
      end else if (count_q == LIMIT) begin
        count_q <= '0;
        timeout <= 1'b1;
      end else begin
        count_q <= count_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller (optional perf counters: PIPE_CTRL_PERF_EN)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               exc_valid,
  input  logic [31:0]        exc_handler,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic               mem_timeout,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        flush_count
);

  pipe_state_t        state_q;
  logic [STALL_W-1:0] stall_d;
  logic               wd_count_en;

  // Combinational stall: exception freezes everything, FLUSH releases everything
  always_comb begin
    stall_d = STALL_NONE;
    if (state_q == PIPE_RUN) begin
      if (exc_valid) begin
        stall_d = STALL_ALL;
      end else begin
        stall_d = stall_select({stallreq_mem, stallreq_ex, stallreq_id, stallreq_if});
      end
    end
  end

  assign stall = stall_d;

  // RUN/FLUSH sequencer with registered flush and latched handler PC
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q <= PIPE_RUN;
      flush   <= 1'b0;
      new_pc  <= ZERO_WORD;
    end else begin
      case (state_q)
        PIPE_RUN: begin
          if (exc_valid) begin
            state_q <= PIPE_FLUSH;
            flush   <= 1'b1;
            new_pc  <= exc_handler;
          end else begin
            flush   <= 1'b0;
          end
        end
        PIPE_FLUSH: begin
          state_q <= PIPE_RUN;
          flush   <= 1'b0;
        end
        default: begin
          state_q <= PIPE_RUN;
          flush   <= 1'b0;
        end
      endcase
    end
  end

  // An exception cycle is not a bus wait, so it breaks the consecutive run
  assign wd_count_en = (state_q == PIPE_RUN) && stallreq_mem && !exc_valid;

  pipe_ctrl_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clk      (clk),
    .rst      (rst),
    .count_en (wd_count_en),
    .timeout  (mem_timeout)
  );

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Wrapping performance counters: frozen cycles and exception flushes
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_d != STALL_NONE) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if ((state_q == PIPE_RUN) && exc_valid) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the five-stage MIPS core. It combines per-stage stall requests into one stall vector that freezes the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences exception flushes by issuing a one-cycle flush together with the handler PC, and watches for memory stalls that never end. It sits beside the datapath and drives the stall and flush inputs of every pipeline register.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: consecutive mem-stall cycles before a timeout pulse; range 1..65535.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stallreq_if  in  1  fetch stage requests a stall
- stallreq_id  in  1  decode stage requests a stall (load-use)
- stallreq_ex  in  1  execute stage requests a stall (multi-cycle op)
- stallreq_mem  in  1  memory stage requests a stall (bus wait)
- exc_valid  in  1  memory stage reports an exception this cycle
- exc_handler  in  32  handler address, qualified by exc_valid
- stall  out  6  freeze vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
- flush  out  1  clear all pipeline registers to NOP
- new_pc  out  32  PC to load while flush=1
- mem_timeout  out  1  one-cycle pulse when the memory stall exceeds MEM_TIMEOUT
- stall_cycles  out  32  performance counter (see Configuration)
- flush_count  out  16  performance counter (see Configuration)

## Operation
- FSM states: RUN, FLUSH. Reset enters RUN.
- **RUN, exc_valid=1:**
  - stall=6'b111111, combinational.
  - At the next edge: latch exc_handler into new_pc and go to FLUSH.
  - Exception takes precedence over every stall request.
- **RUN, exc_valid=0:** stall is combinational and picks the highest-priority request:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - no request: 6'b000000
- **FLUSH:**
  - flush=1, stall=0, new_pc holds the latched handler.
  - Return to RUN unconditionally after one cycle.
  - exc_valid and all stall requests are ignored in this state.
- **Watchdog:**
  - 16-bit counter, incremented while in RUN with stallreq_mem=1 and exc_valid=0; cleared otherwise.
  - When the counter reaches MEM_TIMEOUT: mem_timeout=1 for that cycle (registered) and the counter reloads to 0.
  - Raising mem_timeout does not change stall; the mem stage decides what to do with it.
- flush=0 in RUN. new_pc keeps its last latched value outside FLUSH; its content there is don't-care.

## Timing
- Reset values (after a clocked rst=1):
  - state=RUN
  - flush=0
  - new_pc=32'h0
  - stall=0 (with all requests low)
  - mem_timeout=0
  - watchdog=0
  - stall_cycles=0
  - flush_count=0
- Stall latency: 0 cycles; it is combinational from the requests.
- Flush latency: exc_valid in cycle t gives flush=1 and new_pc=handler in cycle t+1, and normal operation resumes in t+2.
- Back-to-back exc_valid in t and t+1: the second is ignored because the FSM is in FLUSH.
- Reset mid-flush: the next cycle is RUN with flush=0.
- Watchdog with stallreq_mem held continuously from cycle 0: mem_timeout is high in cycle MEM_TIMEOUT+1, then again every MEM_TIMEOUT+1 cycles.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments, wrapping, on each cycle with stall!=0.
  - flush_count increments, wrapping, on each entry into FLUSH.
- Not defined: both ports remain present, tied to 0, and no counter flops are generated.

## Structure
- Shared constants go in macro.v:
  - stall encodings STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM, STALL_ALL
  - state encodings PIPE_RUN, PIPE_FLUSH
  - the width macro for the stall vector
- The existing reset-polarity and zero-word macros are reused.
- One sub-module, mem_watchdog: counter, compare and pulse generation; parameterised by MEM_TIMEOUT.

## Test plan
- **Stall priority:** stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111 in the same cycle. Drop stallreq_ex -> stall=6'b000111.
- **Exception flush:** exc_valid=1, exc_handler=32'hBFC00380 in cycle 5 with stallreq_mem=1 -> stall=6'b111111 in cycle 5; flush=1, new_pc=32'hBFC00380, stall=0 in cycle 6; flush=0 in cycle 7.
- **Back-to-back exceptions:** exc_valid high in cycles 5 and 6 -> exactly one flush pulse (cycle 6); with PERF_EN, flush_count=1.
- **Watchdog:** MEM_TIMEOUT=4, stallreq_mem held high for 12 cycles -> mem_timeout pulses in cycles 5 and 10 only.
- **Reset during FLUSH:** rst=1 in the cycle with flush=1 -> next cycle flush=0, new_pc=0, stall_cycles=0.
- **Performance counters:** with PERF_EN, 7 stall cycles -> stall_cycles=7. Without PERF_EN, stall_cycles stays 0 throughout.
